bias_relu_requant: RTL

- Post-accumulation stage. Sits directly downstream of the ACC stage and consumes its GROUP_SIZE-wide accumulated groups.
- Per group: adds a per-position bias from an internal bias table, optionally applies ReLU, arithmetic-right-shifts, and saturates to OUT_WIDTH.
- Forwards the result to the next stage using the same valid/avail handshake.
- Processes a configured number of groups, then disables itself.

---
 rtl/bias_relu_requant.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bias_relu_requant.sv
// bias_relu_requant: per-group bias add, optional ReLU, arithmetic shift and saturation
// behind a 4-slot input FIFO, forwarding groups through a 3-stage pipeline.
module bias_relu_requant #(
    parameter int DATA_WIDTH    = 16,
    parameter int OUT_WIDTH     = 8,
    parameter int GROUP_SIZE    = 4,
    parameter int NUM_BIAS      = 64,
    parameter int LOG_NUM_BIAS  = 6,
    parameter int LOG_MAX_ITEMS = 16,
    parameter int LOG_MAX_SHIFT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ITEMS-1:0]         num_items,
    input  logic [LOG_NUM_BIAS:0]            num_bias_entries,
    input  logic                             relu_en,
    input  logic [LOG_MAX_SHIFT-1:0]         shift,
    input  logic                             bias_write,
    input  logic [LOG_NUM_BIAS-1:0]          bias_addr,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] bias_data,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*OUT_WIDTH-1:0]  data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             busy
);
    localparam int LW = GROUP_SIZE*DATA_WIDTH;
    localparam int SW = DATA_WIDTH+1;
    localparam int BW = LOG_NUM_BIAS+1;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic [LW-1:0]                 fifo_q [4];
    logic [1:0]                    wr_q, rd_q;
    logic [2:0]                    count_q, count_d;
    logic                          empty, full, push, pop;
    logic                          enabled_q, relu_q;
    logic [LOG_MAX_ITEMS-1:0]      items_q;
    logic [BW-1:0]                 nbe_q, idx_inc;
    logic [LOG_MAX_SHIFT-1:0]      shift_q;
    logic [LOG_NUM_BIAS-1:0]       bias_idx_q, bias_idx_d;
    logic [LW-1:0]                 bias_mem [NUM_BIAS];
    logic                          s1_v_q, s2_v_q, valid_out_q;
    logic [LW-1:0]                 s1_data_q, s1_bias_q;
    logic [GROUP_SIZE*SW-1:0]      s2_sum_q, s2_sum_d;
    logic [GROUP_SIZE*OUT_WIDTH-1:0] data_out_q, data_out_d;

    assign empty     = count_q == 3'd0;
    assign full      = count_q == 3'd4;
    assign avail_out = count_q < 3'd3;
    assign pop       = enabled_q & ~empty & avail_in & ~configure;
    // a write into a full FIFO still lands when the head leaves on the same edge
    assign push      = valid_in & (~full | pop);
    assign count_d   = count_q + 3'(push) - 3'(pop);
    assign idx_inc   = {1'b0, bias_idx_q} + BW'(1);
    assign bias_idx_d = configure ? '0 :
                        pop ? (idx_inc == nbe_q ? '0 : idx_inc[LOG_NUM_BIAS-1:0]) : bias_idx_q;
    assign busy      = enabled_q | s1_v_q | s2_v_q | valid_out_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;

    always_ff @(posedge clk)
        if (push) fifo_q[wr_q] <= data_in;

    always_ff @(posedge clk)
        if (bias_write & ~busy) bias_mem[bias_addr] <= bias_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + 2'(push);
            rd_q    <= rd_q + 2'(pop);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            enabled_q  <= 1'b0;
            items_q    <= '0;
            nbe_q      <= BW'(1);
            relu_q     <= 1'b0;
            shift_q    <= '0;
            bias_idx_q <= '0;
        end else begin
            bias_idx_q <= bias_idx_d;
            if (configure) begin
                enabled_q <= num_items != '0;
                items_q   <= num_items;
                nbe_q     <= num_bias_entries == '0 ? BW'(1) : num_bias_entries;
                relu_q    <= relu_en;
                shift_q   <= shift;
            end else if (pop) begin
                items_q   <= items_q - LOG_MAX_ITEMS'(1);
                enabled_q <= items_q != LOG_MAX_ITEMS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            valid_out_q <= 1'b0;
            s1_data_q   <= '0;
            s1_bias_q   <= '0;
            s2_sum_q    <= '0;
            data_out_q  <= '0;
        end else begin
            s1_v_q      <= pop;
            s2_v_q      <= s1_v_q & ~configure;
            valid_out_q <= s2_v_q & ~configure;
            if (pop) begin
                s1_data_q <= fifo_q[rd_q];
                s1_bias_q <= bias_mem[bias_idx_q];
            end
            if (s1_v_q) s2_sum_q <= s2_sum_d;
            if (s2_v_q & ~configure) data_out_q <= data_out_d;
        end
    end

    for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] d, b;
        logic signed [SW-1:0]  sum, r;
        assign d = s1_data_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign b = s1_bias_q[g*DATA_WIDTH +: DATA_WIDTH];
        assign sum = $signed({d[DATA_WIDTH-1], d}) + $signed({b[DATA_WIDTH-1], b});
        assign s2_sum_d[g*SW +: SW] = (relu_q && sum[SW-1]) ? '0 : sum;
        assign r = $signed(s2_sum_q[g*SW +: SW]) >>> shift_q;
        assign data_out_d[g*OUT_WIDTH +: OUT_WIDTH] = r > MAXV ? MAXV[OUT_WIDTH-1:0] :
                                                      r < MINV ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
    end
endmodule
